// File: rtl/config_memory_writer.sv
// config_memory_writer: unpacks QCFG byte-stream frames into big-endian words on the config memory write port.
// Optional macro CONFIG_MEMORY_WRITER_LOCK_EN adds wr_lock_i, which parses frames without writing or reloading.
module config_memory_writer #(
    parameter int          ADDR_W = 10,
    parameter int          DEPTH  = 1024,
    parameter logic [31:0] MAGIC  = 32'h51434647
) (
    input  logic              clk,
    input  logic              reset,
`ifdef CONFIG_MEMORY_WRITER_LOCK_EN
    input  logic              wr_lock_i,
`endif
    input  logic [7:0]        s_data_i,
    input  logic              s_valid_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    output logic              bram_we_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [31:0]       bram_din_o,
    output logic              reload_o,
    output logic [15:0]       ok_count_o,
    output logic [15:0]       err_count_o,
    output logic [2:0]        last_err_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        S_MAGIC = 3'd0,
        S_START = 3'd1,
        S_COUNT = 3'd2,
        S_DATA  = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_DROP  = 3'd6
    } state_t;

    localparam logic [2:0]  ERR_NONE   = 3'd0;
    localparam logic [2:0]  ERR_MAGIC  = 3'd1;
    localparam logic [2:0]  ERR_RANGE  = 3'd2;
    localparam logic [2:0]  ERR_EARLY  = 3'd3;
    localparam logic [2:0]  ERR_CSUM   = 3'd4;
    localparam logic [2:0]  ERR_NOLAST = 3'd5;
    localparam logic [2:0]  ERR_LOCK   = 3'd6;
    localparam logic [16:0] DEPTH_L    = 17'(DEPTH);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t              r_state;
    logic [1:0]          r_byte_cnt;
    logic [23:0]         r_shift;
    logic [15:0]         r_start;
    logic [15:0]         r_count;
    logic [15:0]         r_word_idx;
    logic [31:0]         r_csum;
    logic                r_lock;
    logic                r_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_din;
    logic                r_reload;
    logic [15:0]         r_ok_cnt;
    logic [15:0]         r_err_cnt;
    logic [2:0]          r_last_err;
    logic                r_busy;

    logic                w_acc;
    logic [31:0]         w_word;
    logic [15:0]         w_half;
    logic [16:0]         w_sum17;
    logic [15:0]         w_next_idx;
    logic                w_last_word;
    logic [ADDR_W-1:0]   w_addr;
    logic [2:0]          w_err_code;

    assign w_acc       = s_valid_i & r_ready;
    assign w_word      = {r_shift, s_data_i};
    assign w_half      = {r_shift[7:0], s_data_i};
    assign w_sum17     = {1'b0, r_start} + {1'b0, w_half};
    assign w_next_idx  = r_word_idx + 16'd1;
    assign w_last_word = (w_next_idx == r_count);
    assign w_addr      = r_start[ADDR_W-1:0] + r_word_idx[ADDR_W-1:0];

    // Classify the byte being accepted this cycle into a rejection code (ERR_NONE if it is fine).
    always_comb begin
        w_err_code = ERR_NONE;
        if (w_acc) begin
            case (r_state)
                S_MAGIC: begin
                    if (r_byte_cnt == 2'd3 && w_word != MAGIC) w_err_code = ERR_MAGIC;
                    else if (s_last_i)                         w_err_code = ERR_EARLY;
                    else                                       w_err_code = ERR_NONE;
                end
                S_START, S_DATA: begin
                    if (s_last_i) w_err_code = ERR_EARLY;
                    else          w_err_code = ERR_NONE;
                end
                S_COUNT: begin
                    if (r_byte_cnt == 2'd1 && (w_half == 16'd0 || w_sum17 > DEPTH_L)) w_err_code = ERR_RANGE;
                    else if (s_last_i)                                                w_err_code = ERR_EARLY;
                    else                                                              w_err_code = ERR_NONE;
                end
                S_CSUM: begin
                    if (r_byte_cnt == 2'd3) begin
                        if (w_word != r_csum) w_err_code = ERR_CSUM;
                        else if (!s_last_i)   w_err_code = ERR_NOLAST;
                        else if (r_lock)      w_err_code = ERR_LOCK;
                        else                  w_err_code = ERR_NONE;
                    end else if (s_last_i) begin
                        w_err_code = ERR_EARLY;
                    end else begin
                        w_err_code = ERR_NONE;
                    end
                end
                default: w_err_code = ERR_NONE;
            endcase
        end else begin
            w_err_code = ERR_NONE;
        end
    end

    // Frame parser state machine with registered memory-port, status and handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_MAGIC;
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
            r_start    <= 16'd0;
            r_count    <= 16'd0;
            r_word_idx <= 16'd0;
            r_csum     <= 32'd0;
            r_lock     <= 1'b0;
            r_ready    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= {ADDR_W{1'b0}};
            r_din      <= 32'd0;
            r_reload   <= 1'b0;
            r_ok_cnt   <= 16'd0;
            r_err_cnt  <= 16'd0;
            r_last_err <= 3'd0;
            r_busy     <= 1'b0;
        end else begin
            r_we     <= 1'b0;
            r_reload <= 1'b0;
            r_ready  <= 1'b1;
            if (w_acc) begin
                r_shift    <= w_word[23:0];
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            // A rejected frame either ends here (last seen) or is drained in S_DROP.
            if (w_err_code != ERR_NONE) begin
                r_err_cnt  <= sat_inc(r_err_cnt);
                r_last_err <= w_err_code;
                r_byte_cnt <= 2'd0;
                r_state    <= s_last_i ? S_MAGIC : S_DROP;
                r_busy     <= ~s_last_i;
            end else begin
                case (r_state)
                    S_MAGIC: begin
                        if (w_acc) begin
                            r_busy <= 1'b1;
                            if (r_byte_cnt == 2'd3) begin
                                r_state <= S_START;
`ifdef CONFIG_MEMORY_WRITER_LOCK_EN
                                r_lock  <= wr_lock_i;
`else
                                r_lock  <= 1'b0;
`endif
                            end
                        end
                    end
                    S_START: begin
                        if (w_acc && r_byte_cnt == 2'd1) begin
                            r_start    <= w_half;
                            r_byte_cnt <= 2'd0;
                            r_state    <= S_COUNT;
                        end
                    end
                    S_COUNT: begin
                        if (w_acc && r_byte_cnt == 2'd1) begin
                            r_count    <= w_half;
                            r_word_idx <= 16'd0;
                            r_csum     <= 32'd0;
                            r_byte_cnt <= 2'd0;
                            r_state    <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_acc && r_byte_cnt == 2'd3) begin
                            r_we       <= ~r_lock;
                            r_addr     <= w_addr;
                            r_din      <= w_word;
                            r_csum     <= r_csum + w_word;
                            r_word_idx <= w_next_idx;
                            if (w_last_word) begin
                                r_state <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (w_acc && r_byte_cnt == 2'd3) begin
                            r_reload <= 1'b1;
                            r_ok_cnt <= sat_inc(r_ok_cnt);
                            r_ready  <= 1'b0;
                            r_state  <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_state    <= S_MAGIC;
                        r_byte_cnt <= 2'd0;
                        r_busy     <= 1'b0;
                    end
                    S_DROP: begin
                        if (w_acc && s_last_i) begin
                            r_state    <= S_MAGIC;
                            r_byte_cnt <= 2'd0;
                            r_busy     <= 1'b0;
                        end
                    end
                    default: begin
                        r_state    <= S_MAGIC;
                        r_byte_cnt <= 2'd0;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign s_ready_o   = r_ready;
    assign bram_we_o   = r_we;
    assign bram_addr_o = r_addr;
    assign bram_din_o  = r_din;
    assign reload_o    = r_reload;
    assign ok_count_o  = r_ok_cnt;
    assign err_count_o = r_err_cnt;
    assign last_err_o  = r_last_err;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_config_memory_writer.sv
// Directed bench for config_memory_writer: frames built byte by byte, writes and reloads captured by a monitor.
module tb_config_memory_writer;

    localparam logic [31:0] MAGIC = 32'h51434647;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data_i;
    logic        s_valid_i;
    logic        s_last_i;
    logic        s_ready_o;
    logic        bram_we_o;
    logic [9:0]  bram_addr_o;
    logic [31:0] bram_din_o;
    logic        reload_o;
    logic [15:0] ok_count_o;
    logic [15:0] err_count_o;
    logic [2:0]  last_err_o;
    logic        busy_o;
`ifdef CONFIG_MEMORY_WRITER_LOCK_EN
    logic        wr_lock_i;
`endif

    config_memory_writer dut (
        .clk         (clk),
        .reset       (reset),
`ifdef CONFIG_MEMORY_WRITER_LOCK_EN
        .wr_lock_i   (wr_lock_i),
`endif
        .s_data_i    (s_data_i),
        .s_valid_i   (s_valid_i),
        .s_last_i    (s_last_i),
        .s_ready_o   (s_ready_o),
        .bram_we_o   (bram_we_o),
        .bram_addr_o (bram_addr_o),
        .bram_din_o  (bram_din_o),
        .reload_o    (reload_o),
        .ok_count_o  (ok_count_o),
        .err_count_o (err_count_o),
        .last_err_o  (last_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          reload_total = 0;
    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  fb[$];

    always @(negedge clk) begin
        if (bram_we_o === 1'b1) begin
            wa_q.push_back(bram_addr_o);
            wd_q.push_back(bram_din_o);
        end
        if (reload_o === 1'b1) reload_total++;
    end

    task automatic push16(input logic [15:0] v);
        fb.push_back(v[15:8]);
        fb.push_back(v[7:0]);
    endtask

    task automatic push32(input logic [31:0] v);
        push16(v[31:16]);
        push16(v[15:0]);
    endtask

    task automatic head(input logic [31:0] magic, input logic [15:0] start, input logic [15:0] cnt);
        fb.delete();
        push32(magic);
        push16(start);
        push16(cnt);
    endtask

    task automatic good_frame();
        head(MAGIC, 16'h0000, 16'h0002);
        push32(32'h0A0300FF);
        push32(32'hFF000000);
        push32(32'h090300FF);
    endtask

    // Sends fb[]; s_last_i is raised on index last_idx (-1 = never). Entered and left on a negedge.
    task automatic send_frame(input int last_idx, input bit stall);
        int guard;
        for (int i = 0; i < fb.size(); i++) begin
            if (stall && $urandom_range(0, 1) == 1) begin
                s_valid_i = 1'b0;
                s_last_i  = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            s_data_i  = fb[i];
            s_last_i  = (i == last_idx);
            s_valid_i = 1'b1;
            guard = 0;
            while (s_ready_o !== 1'b1 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 20) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: s_ready_o=%b, required 1 within 20 cycles", s_ready_o);
            end
            @(negedge clk);
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bram_we_o, reload_o, busy_o, s_ready_o} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: we/reload/busy/ready=%b required 0000", {bram_we_o, reload_o, busy_o, s_ready_o});
        end
        n_cmp++;
        if ({bram_addr_o, bram_din_o} !== 42'd0) begin
            n_bad++; $display("FAIL reset_bus: addr=%h din=%h required 0/0", bram_addr_o, bram_din_o);
        end
        n_cmp++;
        if ({ok_count_o, err_count_o, last_err_o} !== 35'd0) begin
            n_bad++; $display("FAIL reset_counts: ok=%0d err=%0d last_err=%0d required 0", ok_count_o, err_count_o, last_err_o);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_release: ready=%b busy=%b required 1/0", s_ready_o, busy_o);
        end
    endtask

    task automatic test_good_frame();
        int wb = wa_q.size();
        int rb = reload_total;
        good_frame();
        send_frame(fb.size() - 1, 1'b0);
        n_cmp++;
        if (wa_q.size() - wb !== 2) begin
            n_bad++; $display("FAIL good_nwrites: got %0d required 2", wa_q.size() - wb);
        end
        n_cmp++;
        if (wa_q[wb] !== 10'h000 || wd_q[wb] !== 32'h0A0300FF) begin
            n_bad++; $display("FAIL good_write0: got (%h,%h) required (000,0a0300ff)", wa_q[wb], wd_q[wb]);
        end
        n_cmp++;
        if (wa_q[wb+1] !== 10'h001 || wd_q[wb+1] !== 32'hFF000000) begin
            n_bad++; $display("FAIL good_write1: got (%h,%h) required (001,ff000000)", wa_q[wb+1], wd_q[wb+1]);
        end
        n_cmp++;
        if (reload_total - rb !== 1) begin
            n_bad++; $display("FAIL good_reload: got %0d pulses required 1", reload_total - rb);
        end
        n_cmp++;
        if (ok_count_o !== 16'd1 || err_count_o !== 16'd0 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL good_counts: ok=%0d err=%0d busy=%b required 1/0/0", ok_count_o, err_count_o, busy_o);
        end
    endtask

    task automatic test_bad_magic();
        int wb = wa_q.size();
        fb.delete();
        push32(32'h51434646);
        for (int i = 0; i < 20; i++) fb.push_back(8'(i + 1));
        send_frame(fb.size() - 1, 1'b0);
        n_cmp++;
        if (wa_q.size() - wb !== 0 || last_err_o !== 3'd1 || err_count_o !== 16'd1) begin
            n_bad++; $display("FAIL bad_magic: writes=%0d last_err=%0d err=%0d required 0/1/1", wa_q.size() - wb, last_err_o, err_count_o);
        end
        good_frame();
        send_frame(fb.size() - 1, 1'b0);
        n_cmp++;
        if (wa_q.size() - wb !== 2 || ok_count_o !== 16'd2) begin
            n_bad++; $display("FAIL bad_magic_recover: writes=%0d ok=%0d required 2/2", wa_q.size() - wb, ok_count_o);
        end
    endtask

    task automatic test_range();
        int wb = wa_q.size();
        head(MAGIC, 16'h03FF, 16'h0002);
        push32(32'h11111111);
        push32(32'h22222222);
        push32(32'h33333333);
        send_frame(fb.size() - 1, 1'b0);
        n_cmp++;
        if (wa_q.size() - wb !== 0 || last_err_o !== 3'd2 || err_count_o !== 16'd2 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL range_over: writes=%0d last_err=%0d err=%0d busy=%b required 0/2/2/0", wa_q.size() - wb, last_err_o, err_count_o, busy_o);
        end
        wb = wa_q.size();
        head(MAGIC, 16'h03FE, 16'h0002);
        push32(32'h11111111);
        push32(32'h22222222);
        push32(32'h33333333);
        send_frame(fb.size() - 1, 1'b0);
        n_cmp++;
        if (wa_q.size() - wb !== 2 || wa_q[wb] !== 10'h3FE || wa_q[wb+1] !== 10'h3FF || wd_q[wb+1] !== 32'h22222222 || ok_count_o !== 16'd3) begin
            n_bad++; $display("FAIL range_edge: writes=%0d addr1=%h data1=%h ok=%0d required 2/3ff/22222222/3", wa_q.size() - wb, wa_q[wb+1], wd_q[wb+1], ok_count_o);
        end
        wb = wa_q.size();
        head(MAGIC, 16'h0000, 16'h0000);
        push32(32'h00000000);
        send_frame(fb.size() - 1, 1'b0);
        n_cmp++;
        if (wa_q.size() - wb !== 0 || last_err_o !== 3'd2 || err_count_o !== 16'd3) begin
            n_bad++; $display("FAIL range_zero: writes=%0d last_err=%0d err=%0d required 0/2/3", wa_q.size() - wb, last_err_o, err_count_o);
        end
    endtask

    task automatic test_csum_err();
        int wb = wa_q.size();
        int rb = reload_total;
        head(MAGIC, 16'h0000, 16'h0002);
        push32(32'h0A0300FF);
        push32(32'hFF000000);
        push32(32'h090300FE);
        send_frame(fb.size() - 1, 1'b0);
        n_cmp++;
        if (wa_q.size() - wb !== 2 || reload_total - rb !== 0 || last_err_o !== 3'd4 || err_count_o !== 16'd4) begin
            n_bad++; $display("FAIL csum_err: writes=%0d reloads=%0d last_err=%0d err=%0d required 2/0/4/4", wa_q.size() - wb, reload_total - rb, last_err_o, err_count_o);
        end
    endtask

    task automatic test_early_last();
        int wb = wa_q.size();
        int rb = reload_total;
        head(MAGIC, 16'h0010, 16'h0002);
        fb.push_back(8'hAA);
        fb.push_back(8'hBB);
        send_frame(fb.size() - 1, 1'b0);
        n_cmp++;
        if (wa_q.size() - wb !== 0 || last_err_o !== 3'd3 || err_count_o !== 16'd5 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL early_last: writes=%0d last_err=%0d err=%0d busy=%b required 0/3/5/0", wa_q.size() - wb, last_err_o, err_count_o, busy_o);
        end
        good_frame();
        fb.push_back(8'h00);
        send_frame(fb.size() - 1, 1'b0);
        n_cmp++;
        if (reload_total - rb !== 0 || last_err_o !== 3'd5 || err_count_o !== 16'd6 || ok_count_o !== 16'd3) begin
            n_bad++; $display("FAIL missing_last: reloads=%0d last_err=%0d err=%0d ok=%0d required 0/5/6/3", reload_total - rb, last_err_o, err_count_o, ok_count_o);
        end
    endtask

    task automatic test_back_to_back_stall();
        int wb = wa_q.size();
        int rb = reload_total;
        good_frame();
        send_frame(fb.size() - 1, 1'b1);
        n_cmp++;
        if (wa_q.size() - wb !== 2 || wd_q[wb] !== 32'h0A0300FF || wd_q[wb+1] !== 32'hFF000000 || wa_q[wb+1] !== 10'h001) begin
            n_bad++; $display("FAIL stall_writes: n=%0d d0=%h d1=%h a1=%h required 2/0a0300ff/ff000000/001", wa_q.size() - wb, wd_q[wb], wd_q[wb+1], wa_q[wb+1]);
        end
        n_cmp++;
        if (reload_total - rb !== 1 || ok_count_o !== 16'd4) begin
            n_bad++; $display("FAIL stall_reload: reloads=%0d ok=%0d required 1/4", reload_total - rb, ok_count_o);
        end
    endtask

    task automatic test_reset_mid_frame();
        int wb = wa_q.size();
        head(MAGIC, 16'h0005, 16'h0003);
        push32(32'hDEADBEEF);
        fb.push_back(8'h12);
        fb.push_back(8'h34);
        send_frame(-1, 1'b0);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bram_we_o, reload_o, busy_o, s_ready_o, bram_addr_o, bram_din_o, ok_count_o, err_count_o, last_err_o} !== 81'd0) begin
            n_bad++; $display("FAIL reset_mid_outputs: we=%b busy=%b ready=%b addr=%h din=%h ok=%0d err=%0d required all 0", bram_we_o, busy_o, s_ready_o, bram_addr_o, bram_din_o, ok_count_o, err_count_o);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (wa_q.size() - wb !== 1 || wa_q[wb] !== 10'h005 || wd_q[wb] !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL reset_mid_writes: n=%0d a0=%h d0=%h required 1/005/deadbeef", wa_q.size() - wb, wa_q[wb], wd_q[wb]);
        end
        n_cmp++;
        if (s_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_release: ready=%b busy=%b required 1/0", s_ready_o, busy_o);
        end
    endtask

`ifdef CONFIG_MEMORY_WRITER_LOCK_EN
    task automatic test_lock();
        int wb = wa_q.size();
        int rb = reload_total;
        wr_lock_i = 1'b1;
        good_frame();
        send_frame(fb.size() - 1, 1'b0);
        wr_lock_i = 1'b0;
        n_cmp++;
        if (wa_q.size() - wb !== 0 || reload_total - rb !== 0 || last_err_o !== 3'd6 || err_count_o !== 16'd1) begin
            n_bad++; $display("FAIL lock: writes=%0d reloads=%0d last_err=%0d err=%0d required 0/0/6/1", wa_q.size() - wb, reload_total - rb, last_err_o, err_count_o);
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        s_data_i  = 8'h00;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
`ifdef CONFIG_MEMORY_WRITER_LOCK_EN
        wr_lock_i = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_magic();
        test_range();
        test_csum_err();
        test_early_last();
        test_back_to_back_stall();
        test_reset_mid_frame();
`ifdef CONFIG_MEMORY_WRITER_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
